// File: rtl/wb_port_arbiter_if.sv
// Bundle of the WB-stage, MDU and regfile write-port signals around the arbiter.
// The arbiter takes the slave view; the producer/consumer side takes the master view.
interface wb_port_arbiter_if #(
    parameter int RF_ADDR_WD = 5,
    parameter int RF_DATA_WD = 64
);
    logic                             a_valid;
    logic                             a_we;
    logic [RF_ADDR_WD-1:0]            a_waddr;
    logic [RF_DATA_WD-1:0]            a_wdata;
    logic                             a_ready;
    logic                             b_valid;
    logic [RF_ADDR_WD-1:0]            b_waddr;
    logic [RF_DATA_WD-1:0]            b_wdata;
    logic                             b_ready;
    logic                             rf_we;
    logic [RF_ADDR_WD-1:0]            rf_waddr;
    logic [RF_DATA_WD-1:0]            rf_wdata;
    logic [RF_DATA_WD+RF_ADDR_WD:0]   fwd_bus;
    logic                             b_pending;

    modport slave (
        input  a_valid, a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
        output a_ready, b_ready, rf_we, rf_waddr, rf_wdata, fwd_bus, b_pending
    );

    modport master (
        output a_valid, a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
        input  a_ready, b_ready, rf_we, rf_waddr, rf_wdata, fwd_bus, b_pending
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter: in-order WB (A) normally wins, MDU results (B) are
// buffered in a small FIFO and forced through after STARVE_MAX consecutive A wins.
module wb_port_arbiter #(
    parameter int RF_ADDR_WD = 5,
    parameter int RF_DATA_WD = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               reset,
    wb_port_arbiter_if.slave   bus
);
    localparam int PTR_WD = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_WD = PTR_WD + 1;
    localparam int STV_WD = $clog2(STARVE_MAX + 1);

    logic [RF_ADDR_WD-1:0] addr_mem_q [FIFO_DEPTH];
    logic [RF_DATA_WD-1:0] data_mem_q [FIFO_DEPTH];
    logic [PTR_WD-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_WD-1:0]     count_q, count_d;
    logic [STV_WD-1:0]     starve_q, starve_d;
    logic                  rf_we_q, rf_we_d;
    logic [RF_ADDR_WD-1:0] rf_waddr_q, rf_waddr_d;
    logic [RF_DATA_WD-1:0] rf_wdata_q, rf_wdata_d;

    logic a_req, b_head_v, full, starved, grant_a, grant_b, push, pop;
    logic [RF_ADDR_WD-1:0] head_addr;
    logic [RF_DATA_WD-1:0] head_data;

    assign a_req     = bus.a_valid & bus.a_we;
    assign b_head_v  = (count_q != '0);
    assign full      = (count_q == CNT_WD'(FIFO_DEPTH));
    assign starved   = (starve_q == STV_WD'(STARVE_MAX));
    assign grant_b   = b_head_v & (~a_req | starved);
    assign grant_a   = a_req & ~grant_b;
    // Push is gated by the registered full flag only, so a full FIFO never
    // accepts even when its head drains in the same cycle.
    assign push      = bus.b_valid & ~full;
    assign pop       = grant_b;
    assign head_addr = addr_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];

    assign bus.a_ready   = ~a_req | grant_a;
    assign bus.b_ready   = ~full;
    assign bus.b_pending = b_head_v;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.fwd_bus   = {rf_we_q, rf_wdata_q, rf_waddr_q};

    always_comb begin
        count_d    = count_q;
        starve_d   = starve_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (push && !pop)
            count_d = count_q + CNT_WD'(1);
        else if (pop && !push)
            count_d = count_q - CNT_WD'(1);
        if (grant_b || !b_head_v)
            starve_d = '0;
        else if (grant_a && !starved)
            starve_d = starve_q + STV_WD'(1);
        // x0 writes still consume the grant but never raise the enable.
        if (grant_b) begin
            rf_we_d    = (head_addr != '0);
            rf_waddr_d = head_addr;
            rf_wdata_d = head_data;
        end else if (grant_a) begin
            rf_we_d    = (bus.a_waddr != '0);
            rf_waddr_d = bus.a_waddr;
            rf_wdata_d = bus.a_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            if (push) begin
                addr_mem_q[wr_ptr_q] <= bus.b_waddr;
                data_mem_q[wr_ptr_q] <= bus.b_wdata;
                wr_ptr_q             <= wr_ptr_q + PTR_WD'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_WD'(1);
            count_q    <= count_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter: a queue-based reference model
// predicts handshakes and regfile writes; a monitor checks each write as it appears.
module tb_wb_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int DEPTH = 2;
    localparam int SMAX = 3;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    wr_t  exp_q[$];
    wr_t  fifo_m[$];
    int   starve_m = 0;

    wb_port_arbiter_if #(.RF_ADDR_WD(AW), .RF_DATA_WD(DW)) bus ();

    wb_port_arbiter #(
        .RF_ADDR_WD(AW), .RF_DATA_WD(DW), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.a_valid = 1'b0; bus.a_we = 1'b0; bus.a_waddr = '0; bus.a_wdata = '0;
        bus.b_valid = 1'b0; bus.b_waddr = '0; bus.b_wdata = '0;
    endtask

    // One cycle of stimulus; the model decides grants from the arbitration rules.
    task automatic cycle(input logic av, input logic we, input logic [AW-1:0] aa,
                         input logic [DW-1:0] ad, input logic bv,
                         input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        bit a_req, hv, gb, ga, room;
        wr_t w;
        @(negedge clk);
        bus.a_valid = av; bus.a_we = we; bus.a_waddr = aa; bus.a_wdata = ad;
        bus.b_valid = bv; bus.b_waddr = ba; bus.b_wdata = bd;
        #1;
        a_req = av && we;
        hv    = fifo_m.size() > 0;
        room  = fifo_m.size() < DEPTH;
        gb    = hv && (!a_req || starve_m == SMAX);
        ga    = a_req && !gb;
        chk("a_ready", 128'(bus.a_ready), 128'(!a_req || ga));
        chk("b_ready", 128'(bus.b_ready), 128'(room));
        chk("b_pending", 128'(bus.b_pending), 128'(hv));
        if (gb) begin
            w = fifo_m.pop_front();
            if (w.addr != 0) exp_q.push_back(w);
        end else if (ga && aa != 0) begin
            w.addr = aa; w.data = ad;
            exp_q.push_back(w);
        end
        if (bv && room) begin
            w.addr = ba; w.data = bd;
            fifo_m.push_back(w);
        end
        if (gb || !hv) starve_m = 0;
        else if (ga && starve_m < SMAX) starve_m++;
        $display("cyc a=%0b/%0b x%0d b=%0b x%0d gnt_a=%0b gnt_b=%0b fifo=%0d starve=%0d",
                 av, we, aa, bv, ba, ga, gb, fifo_m.size(), starve_m);
    endtask

    // Monitor: each write must appear exactly one cycle after its grant.
    initial begin
        wr_t w;
        forever begin
            @(posedge clk);
            #1;
            if (bus.rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got x%0d=0x%0h expected no write at %0t",
                             bus.rf_waddr, bus.rf_wdata, $time);
                end else begin
                    w = exp_q.pop_front();
                    chk("rf_waddr", 128'(bus.rf_waddr), 128'(w.addr));
                    chk("rf_wdata", 128'(bus.rf_wdata), 128'(w.data));
                    chk("fwd_bus", 128'(bus.fwd_bus), 128'({1'b1, w.data, w.addr}));
                end
            end else if (exp_q.size() != 0) begin
                total++; bad++;
                $display("FAIL missing_write: got rf_we=%0b expected write x%0d at %0t",
                         bus.rf_we, exp_q[0].addr, $time);
                exp_q.delete();
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rf_we", 128'(bus.rf_we), 128'(0));
        chk("reset_rf_waddr", 128'(bus.rf_waddr), 128'(0));
        chk("reset_rf_wdata", 128'(bus.rf_wdata), 128'(0));
        chk("reset_b_pending", 128'(bus.b_pending), 128'(0));
        reset = 1'b0;
        #1;
        chk("reset_b_ready", 128'(bus.b_ready), 128'(1));

        repeat (4) cycle(1, 1, 5, 64'h11, 0, 0, 0);

        cycle(0, 0, 0, 0, 1, 7, 64'hBEEF);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3; i++)
            cycle(1, 1, 3, 64'(32'h100 + i), 1, AW'(8 + i), 64'(32'hB00 + i));
        repeat (5) cycle(1, 1, 3, 64'h3333, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);

        cycle(0, 0, 0, 0, 1, 12, 64'hC0DE);
        cycle(1, 0, 4, 64'h4444, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0, 0, 0);

        cycle(1, 1, 0, 64'hFF, 1, 0, 64'h55);
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle with the FIFO full and a write on the port.
        cycle(1, 1, 9, 64'h99, 1, 10, 64'hA0);
        cycle(1, 1, 9, 64'h9A, 1, 11, 64'hA1);
        @(posedge clk);
        #3;
        chk("pre_reset_rf_we", 128'(bus.rf_we), 128'(1));
        chk("pre_reset_full", 128'(bus.b_ready), 128'(0));
        reset = 1'b1;
        drive_idle();
        #1;
        chk("async_rf_we", 128'(bus.rf_we), 128'(0));
        chk("async_b_pending", 128'(bus.b_pending), 128'(0));
        chk("async_b_ready", 128'(bus.b_ready), 128'(1));
        exp_q.delete();
        fifo_m.delete();
        starve_m = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 1), $urandom_range(0, 3) != 0, AW'($urandom),
                  {$urandom, $urandom}, $urandom_range(0, 1), AW'($urandom),
                  {$urandom, $urandom});
        repeat (6) cycle(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("drain_exp_empty", 128'(exp_q.size()), 128'(0));
        chk("drain_b_pending", 128'(bus.b_pending), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
